muldiv_seq: RTL and testbench

//  Parametrised sequential multiply/divide unit. Replaces the separate mult and div blocks.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_mag.sv | 12 +
 rtl/muldiv_seq.sv | 139 +++++++++++++
 tb/tb_muldiv_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return !(op == OP_MULT || op == OP_MULTU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT || op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_mag.sv
// Conditional two's-complement negate: gives |x| for operands and re-applies sign to results.
module muldiv_mag #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? ((~val_i) + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Radix-2 sequential MULT/MULTU/DIV/DIVU unit with MIPS Hi/Lo semantics.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 dz_q, dz_d;

    logic [WIDTH-1:0]     abs_a, abs_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH:0]       mul_sum, div_rem, div_diff;
    logic                 sgn_q, div_mode_q;

    assign sgn_q      = op_is_signed(op_q);
    assign div_mode_q = op_is_div(op_q);

    muldiv_mag #(.W(WIDTH)) u_abs_a (
        .val_i(a), .neg_i(op_is_signed(op) & a[WIDTH-1]), .res_o(abs_a));
    muldiv_mag #(.W(WIDTH)) u_abs_b (
        .val_i(b), .neg_i(op_is_signed(op) & b[WIDTH-1]), .res_o(abs_b));
    muldiv_mag #(.W(2*WIDTH)) u_prod (
        .val_i(acc_q), .neg_i(sgn_q & (sa_q ^ sb_q)), .res_o(prod_fix));
    muldiv_mag #(.W(WIDTH)) u_quo (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(sgn_q & (sa_q ^ sb_q)), .res_o(quo_fix));
    muldiv_mag #(.W(WIDTH)) u_rem (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sgn_q & sa_q), .res_o(rem_fix));

    // Multiply: acc = {partial, multiplier}, shifted right. Divide: acc = {remainder, dividend/quotient}, shifted left.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, opnd_q};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    sa_d  = a[WIDTH-1];
                    sb_d  = b[WIDTH-1];
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (op_is_div(op) && b == '0) begin
                        state_d = ST_DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        opnd_d  = op_is_div(op) ? abs_b : abs_a;
                        acc_d   = {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = ST_DONE;
                    if (div_mode_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!div_mode_q)
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    else if (div_diff[WIDTH])
                        acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    else
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq at WIDTH=32.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit glitch, output int lat, output logic busy0);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        busy0 = busy;
        lat = -1;
        if (done) lat = 0;
        else begin
            for (int n = 1; n <= 60; n++) begin
                if (glitch && n == 5) begin
                    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
                if (done) begin
                    lat = n;
                    break;
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int   lat;
        logic bz;
        bit   seen;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LAT};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT};
        vecs[3]  = '{OP_DIVU,  32'h00002211, 32'h100,      32'h00000011, 32'h00000022, 1'b0, LAT};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'h00000011, 32'h00000022, 1'b1, 0};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT};
        vecs[6]  = '{OP_MULT,  32'd5,        32'd6,        32'h00000000, 32'd30,       1'b0, LAT};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, LAT};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 1'b0, LAT};
        vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT};
        vecs[11] = '{OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT};
        vecs[12] = '{OP_DIV,   32'd5,        32'd0,        32'h00000000, 32'h80000000, 1'b1, 0};
        vecs[13] = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, LAT};
        vecs[14] = '{OP_DIV,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, LAT};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_dz", {31'b0, div_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bz);
            check($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
            check($sformatf("v%0d_busy", i), {31'b0, bz}, 32'd1);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_dz", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
            check($sformatf("v%0d_dz_held", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
            check($sformatf("v%0d_idle", i), {31'b0, busy}, 32'd0);
        end

        // start re-pulsed mid-operation must be ignored
        run_op(OP_MULT, 32'd5, 32'd6, 1'b1, lat, bz);
        check("ignore_latency", W'(lat), W'(LAT));
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd30);
        @(posedge clk);
        @(negedge clk);
        check("ignore_idle", {31'b0, busy}, 32'd0);

        // reset abandons an in-flight operation
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", {31'b0, seen}, 32'd0);

        run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, lat, bz);
        check("post_reset_latency", W'(lat), W'(LAT));
        check("post_reset_hi", hi, 32'hFFFFFFFF);
        check("post_reset_lo", lo, 32'hFFFFFFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
